// File: rtl/bkram_ctrl.sv
// Backup-RAM load/save sequencer: walks sector LBAs through HPS read/write handshakes.
// Autosave on OSD open is built in only when BKRAM_AUTOSAVE_EN is defined.
module bkram_ctrl #(
  parameter int unsigned SECTORS = 64,
  parameter logic [23:0] TIMEOUT = 24'd5000000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        bk_ena,
  input  logic        load_req,
  input  logic        save_req,
  input  logic        mount_load,
  input  logic        osd_open,
  input  logic        nvram_we,
  input  logic        sd_ack,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic        busy,
  output logic        loading,
  output logic        dirty,
  output logic        err
);
  localparam int unsigned LBA_W = (SECTORS > 1) ? $clog2(SECTORS) : 1;
  localparam logic [LBA_W-1:0] LBA_LAST = LBA_W'(SECTORS - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [LBA_W-1:0] lba_q, lba_d;
  logic [23:0]      cnt_q, cnt_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic             busy_q, busy_d;
  logic             loading_q, loading_d;
  logic             dirty_q, dirty_d;
  logic             err_q, err_d;
  logic             dirty_clr;

  logic load_q, save_q, ack_q;
  logic load_rise, save_rise, ack_rise, ack_fall, auto_trig;
  logic start_load, start_save;

  // Edge history follows the inputs every cycle, including during reset.
`ifdef BKRAM_AUTOSAVE_EN
  logic osd_q;
  always_ff @(posedge clk_sys) begin
    load_q <= load_req;
    save_q <= save_req;
    ack_q  <= sd_ack;
    osd_q  <= osd_open;
  end
  assign auto_trig = osd_open & ~osd_q & dirty_q;
`else
  logic unused_osd_open;
  always_ff @(posedge clk_sys) begin
    load_q <= load_req;
    save_q <= save_req;
    ack_q  <= sd_ack;
  end
  assign unused_osd_open = osd_open;
  assign auto_trig       = 1'b0;
`endif

  assign load_rise  = load_req & ~load_q;
  assign save_rise  = save_req & ~save_q;
  assign ack_rise   = sd_ack & ~ack_q;
  assign ack_fall   = ~sd_ack & ack_q;
  // Load sources outrank save sources; the loser is dropped.
  assign start_load = bk_ena & (mount_load | load_rise);
  assign start_save = bk_ena & ~start_load & (save_rise | auto_trig);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= S_IDLE;
      lba_q     <= '0;
      cnt_q     <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      loading_q <= 1'b0;
      dirty_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lba_q     <= lba_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      busy_q    <= busy_d;
      loading_q <= loading_d;
      dirty_q   <= dirty_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lba_d     = lba_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    loading_d = loading_q;
    err_d     = err_q;
    dirty_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_load | start_save) begin
          state_d   = S_REQ;
          lba_d     = '0;
          cnt_d     = '0;
          rd_d      = start_load;
          wr_d      = start_save;
          loading_d = start_load;
          err_d     = 1'b0;
          dirty_clr = start_save;
        end
      end
      S_REQ: begin
        if (ack_rise) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = S_XFER;
        end else if (cnt_q >= TIMEOUT) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      S_XFER: begin
        if (ack_fall) begin
          if (lba_q == LBA_LAST) begin
            state_d = S_DONE;
          end else begin
            lba_d   = lba_q + LBA_W'(1);
            rd_d    = loading_q;
            wr_d    = ~loading_q;
            cnt_d   = '0;
            state_d = S_REQ;
          end
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        loading_d = 1'b0;
        dirty_clr = loading_q & ~err_q;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d  = (state_d != S_IDLE);
    // A write in the same cycle as a clear wins; writes made by the load itself do not count.
    dirty_d = (nvram_we & ~loading_q) | (dirty_q & ~dirty_clr);
  end

  assign sd_lba  = 32'(lba_q);
  assign sd_rd   = rd_q;
  assign sd_wr   = wr_q;
  assign busy    = busy_q;
  assign loading = loading_q;
  assign dirty   = dirty_q;
  assign err     = err_q;
endmodule

// File: doc/bkram_ctrl.md
BKRAM_CTRL -- requirements
Module: bkram_ctrl

Interface
REQ-001 Parameter SECTORS, default 64: number of 512-byte sectors per backup image (power of two, 1..256).
REQ-002 Parameter TIMEOUT, default 24'd5000000: clk_sys cycles allowed from request to sd_ack rise.
REQ-003 clk_sys  in  1  system clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 bk_ena  in  1  save file mounted and writable; when 0, all triggers are ignored.
REQ-006 load_req  in  1  OSD "Load Backup RAM" level; rising edge triggers a load.
REQ-007 save_req  in  1  OSD "Save Backup RAM" level; rising edge triggers a save.
REQ-008 mount_load  in  1  one-cycle pulse at end of ROM download with non-empty image; triggers a load.
REQ-009 osd_open  in  1  OSD visible level; rising edge is the autosave trigger.
REQ-010 nvram_we  in  1  system write strobe to backup RAM; marks the image dirty.
REQ-011 sd_ack  in  1  HPS sector acknowledge; high while a sector is being transferred.
REQ-012 sd_lba  out  32  current sector number, bits above log2(SECTORS) zero.
REQ-013 sd_rd  out  1  sector read request.
REQ-014 sd_wr  out  1  sector write request.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 loading  out  1  high during a load; used to hold the system in reset.
REQ-017 dirty  out  1  backup RAM modified since the last completed load or save start.
REQ-018 err  out  1  sticky timeout flag.

Function
REQ-019 FSM states: IDLE, REQ, XFER, DONE.
REQ-020 IDLE: on trigger -> REQ, sd_lba=0, loading=(op==load), sd_rd=load, sd_wr=~load.
REQ-021 Simultaneous triggers in one cycle: priority is mount_load > load_req > save_req > autosave; lower-priority triggers are dropped.
REQ-022 Triggers arriving while busy are ignored, not queued.
REQ-023 REQ: on sd_ack rising edge, clear sd_rd/sd_wr in the same cycle -> XFER; if the timeout counter reaches TIMEOUT first -> DONE with err=1.
REQ-024 XFER: on sd_ack falling edge, if sd_lba==SECTORS-1 -> DONE; else sd_lba+1, re-assert sd_rd/sd_wr for the same op -> REQ.
REQ-025 The timeout counter clears on every entry to REQ; it does not run in XFER.
REQ-026 DONE: lasts one cycle, clears loading and busy next cycle -> IDLE; a load completion also clears dirty.
REQ-027 dirty is set by nvram_we in any state, cleared on save start; a set in the same cycle wins.
REQ-028 While loading=1, nvram_we is ignored for dirty (the load itself writes the RAM).
REQ-029 err is cleared only by reset or the start of a new operation.
REQ-030 Edge detectors sample inputs every cycle regardless of state, so a level already held high when going IDLE does not retrigger.

Reset
REQ-031 reset forces IDLE, sd_rd=0, sd_wr=0, sd_lba=0, loading=0, busy=0, dirty=0, err=0, counters=0, and edge registers = current inputs.
REQ-032 reset mid-transfer aborts immediately with no further requests; HPS completes the outstanding sector harmlessly.

Configuration
REQ-033 Macro BKRAM_AUTOSAVE_EN defined: an osd_open rising edge with bk_ena=1 and dirty=1 starts a save.
REQ-034 Macro BKRAM_AUTOSAVE_EN undefined: osd_open is unused, with no autosave logic; dirty still tracks as specified.

Verification
REQ-035 SECTORS=4, save_req edge, HPS model acks each request after 10 cycles for 20 cycles -> sd_wr pulses with sd_lba 0,1,2,3, then busy=0, err=0.
REQ-036 mount_load and save_req in the same cycle -> a load runs (sd_rd only), loading=1 throughout, and dirty=0 after DONE.
REQ-037 Macro defined, nvram_we pulse, then osd_open edge -> save starts; repeat osd_open with no writes -> no request.
REQ-038 No sd_ack, TIMEOUT=100 -> err=1 at cycle 101 after the request, sd_rd=0, busy=0 two cycles later.
REQ-039 reset asserted during XFER of sector 2 -> all outputs at reset values next cycle, and no request after reset deasserts.
REQ-040 bk_ena=0, load_req edge -> no sd_rd, busy stays 0.
